nes_joypad: RTL and testbench
=============================

Name: nes_joypad

Overview:
- Controller-side responder for the CPU's $4016/$4017 joypad interface. It emulates two standard NES controllers (4021-style parallel-in/serial-out shift registers).
- Consumes the latch strobe and per-port read pulses generated by the CPU/APU register block. Returns one button bit per read on each port's serial data line.
- Raw, asynchronous board buttons are synchronized and debounced before being latched.

Parameters:
- DEBOUNCE_DIV, 1000: clk cycles per debounce sample tick; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn0_raw  in  8  port 0 raw buttons, async, 1 = pressed; bit order [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
- btn1_raw  in  8  port 1 raw buttons, same encoding
- strobe_i  in  1  latch level (bit 0 of the $4016 write)
- rd_pulse_i  in  2  one-cycle read pulse per port ([0] = $4016 read, [1] = $4017 read)
- data_o  out  2  serial data per port, 1 = pressed; read by the CPU in the same cycle the pulse is asserted
- btn0_state  out  8  debounced port 0 buttons (debug/OSD)
- btn1_state  out  8  debounced port 1 buttons

Behaviour:
- Synchronizer: each raw bit passes through 2 flops (s1, s2); both reset to 0.
- Prescaler:
  - 16-bit counter runs 0..DEBOUNCE_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals DEBOUNCE_DIV-1.
  - DEBOUNCE_DIV=1 gives tick every cycle. Counter resets to 0.
- Debounce, per button:
  - On each tick, shift s2 into a 2-bit history h.
  - If s2, h[0] and h[1] are all equal and differ from state, state takes that value at the same clock edge.
  - h and state reset to 0.
  - Latency from a stable raw change to state: at most 2 + 3*DEBOUNCE_DIV cycles.
  - A glitch shorter than 3 consecutive ticks never changes state.
- Shift register, per port (sr[7:0], reset 8'h00):
  - Priority 1: strobe_i=1 → sr <= debounced state, every cycle (level-sensitive, continuous reload).
  - Priority 2: strobe_i=0 and rd_pulse_i[n]=1 → sr <= {1'b1, sr[7:1]}.
  - Otherwise sr holds.
- Output:
  - data_o[n] = sr[n][0], a direct register output with no extra delay.
  - The first read after the strobe falls returns A, then B, Select, Start, Up, Down, Left, Right.
  - Read 9 and all later reads return 1.
  - Reads while strobe is high always return A of the most recently latched state (reload has priority).
- Ports are independent: a pulse on port 0 never shifts port 1; simultaneous pulses shift both.
- The strobe is shared by both ports.
- Reset mid-sequence: sr, history, state and prescaler all clear. data_o = 2'b00 in the cycle after rst is sampled.
- btn*_state mirror the debounced state registers; reset 0.

Optional Feature:
- Macro: JOYPAD_SOCD_EN.
- Defined:
  - The value loaded into sr applies opposite-direction cleaning.
  - If state Up and Down are both 1, both load as 0. Same rule for Left/Right.
  - btn*_state still report the uncleaned debounced state.
- Undefined: sr loads the debounced state unmodified.
- No port-list change in either case.

Test Plan (DEBOUNCE_DIV=4):
- Reset release with btn0_raw=8'h00, strobe=1 then 0, then 9 rd_pulse[0] pulses → data_o[0] sequence 0,0,0,0,0,0,0,0,1. data_o = 2'b00 immediately after reset.
- btn0_raw=8'b1000_1001 (A, Start, Right) held 20 cycles, strobe 1→0, 10 pulses → reads 1,0,0,1,0,0,0,1,1,1. btn0_state=8'h89.
- btn1_raw bit 1 (B) pulsed high for 6 cycles only (< 3 ticks), then low → btn1_state stays 8'h00 and port 1 reads B=0.
- strobe held 1 with btn0_state=8'h01, three rd_pulse[0] → data_o[0] = 1 each time with no shifting. After strobe falls, the first read is still A=1.
- Interleaved rd_pulse=2'b01, 2'b10, 2'b11 with port 0 = 8'hFF and port 1 = 8'h00 → port 0 shifts twice and port 1 twice, each independently. After 8 of its own pulses, port 1 reads 1.
- JOYPAD_SOCD_EN defined, btn0_raw=8'h30 (Up+Down) → latched sequence reads Up=0, Down=0. btn0_state=8'h30. Without the macro → Up=1, Down=1.

Source files
------------

// File: rtl/nes_joypad.sv
// nes_joypad
//   Controller-side responder for the CPU $4016/$4017 joypad interface.
//   Emulates two standard NES controllers (4021-style parallel-in /
//   serial-out shift registers). Raw board buttons are synchronized and
//   debounced before they can be latched.
//
// Parameters:
//   DEBOUNCE_DIV  clk cycles per debounce sample tick (1..65535)
//
// Optional build macro:
//   JOYPAD_SOCD_EN  when defined, the value latched into the shift
//                   registers has opposite directions cleaned (Up+Down
//                   both pressed -> both released; same for Left+Right).
//                   btn*_state always report the uncleaned state.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   btn0_raw    port 0 raw buttons, async, 1 = pressed
//               [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   btn1_raw    port 1 raw buttons, same encoding
//   strobe_i    latch level (bit 0 of the $4016 write), shared by both ports
//   rd_pulse_i  one-cycle read pulse per port ([0] $4016, [1] $4017)
//   data_o      serial data per port, 1 = pressed
//   btn0_state  debounced port 0 buttons
//   btn1_state  debounced port 1 buttons
//
// Read protocol: there is no back-pressure. While strobe_i is high each
// shift register reloads from the debounced buttons every cycle. With
// strobe_i low, a cycle with rd_pulse_i[n] = 1 is one read of port n: the
// CPU samples data_o[n] during that same cycle, and the register shifts at
// the closing edge so the next bit is presented for the following read.
// Ones are shifted in from the top, so reads 9 and later return 1.

module nes_joypad #(
    parameter int DEBOUNCE_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] btn0_raw,
    input  logic [7:0] btn1_raw,
    input  logic       strobe_i,
    input  logic [1:0] rd_pulse_i,
    output logic [1:0] data_o,
    output logic [7:0] btn0_state,
    output logic [7:0] btn1_state
);

    localparam logic [15:0] DIV_LAST = 16'(DEBOUNCE_DIV - 1);

    // Index [n] selects the controller port.
    logic [1:0][7:0] s1;
    logic [1:0][7:0] s2;
    logic [1:0][7:0] h0;      // most recent previous tick sample
    logic [1:0][7:0] h1;      // sample from the tick before that
    logic [1:0][7:0] state;   // debounced buttons
    logic [1:0][7:0] load_val;
    logic [1:0][7:0] sr;

    logic [15:0] cnt;
    logic        tick;

    // ------------------------------------------------------------------
    // Prescaler: tick in the cycle the count reaches DEBOUNCE_DIV-1.
    // ------------------------------------------------------------------
    assign tick = (cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Synchronizer and debounce. A button changes only when the current
    // synchronized sample and the two previous tick samples all agree,
    // so a glitch covering fewer than three ticks is ignored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            h0    <= '0;
            h1    <= '0;
            state <= '0;
        end else begin
            s1 <= {btn1_raw, btn0_raw};
            s2 <= s1;
            if (tick) begin
                h0 <= s2;
                h1 <= h0;
                for (int n = 0; n < 2; n++) begin
                    state[n] <= (state[n] | (s2[n] & h0[n] & h1[n]))
                              & ~(~s2[n] & ~h0[n] & ~h1[n]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Value presented to the shift registers on reload.
    // ------------------------------------------------------------------
    always_comb begin
        load_val = state;
`ifdef JOYPAD_SOCD_EN
        for (int n = 0; n < 2; n++) begin
            if (state[n][4] && state[n][5]) begin
                load_val[n][5:4] = 2'b00;
            end
            if (state[n][6] && state[n][7]) begin
                load_val[n][7:6] = 2'b00;
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // 4021-style shift registers. Reload has priority over shifting, so
    // reads while strobe is high keep returning A.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (strobe_i) begin
                    sr[n] <= load_val[n];
                end else if (rd_pulse_i[n]) begin
                    sr[n] <= {1'b1, sr[n][7:1]};
                end
            end
        end
    end

    assign data_o     = {sr[1][0], sr[0][0]};
    assign btn0_state = state[0];
    assign btn1_state = state[1];

endmodule

// File: tb/tb_nes_joypad.sv
// tb_nes_joypad
//   Self-checking bench for nes_joypad with DEBOUNCE_DIV = 4. Expected
//   serial bits are pushed into per-port queues when reads are planned and
//   popped/compared when the read pulse is issued.

module tb_nes_joypad;

    localparam int DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] btn0_raw;
    logic [7:0] btn1_raw;
    logic       strobe_i;
    logic [1:0] rd_pulse_i;
    logic [1:0] data_o;
    logic [7:0] btn0_state;
    logic [7:0] btn1_state;

    int    tests_run    = 0;
    int    tests_failed = 0;
    string cur_test     = "none";

    logic [0:0] exp0_q[$];
    logic [0:0] exp1_q[$];

    nes_joypad #(
        .DEBOUNCE_DIV(DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn0_raw   (btn0_raw),
        .btn1_raw   (btn1_raw),
        .strobe_i   (strobe_i),
        .rd_pulse_i (rd_pulse_i),
        .data_o     (data_o),
        .btn0_state (btn0_state),
        .btn1_state (btn1_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model of what a controller should present
    // ------------------------------------------------------------------
    function automatic logic [7:0] model_load(input logic [7:0] v);
        logic [7:0] r;
        r = v;
`ifdef JOYPAD_SOCD_EN
        if (v[4] && v[5]) r[5:4] = 2'b00;
        if (v[6] && v[7]) r[7:6] = 2'b00;
`endif
        return r;
    endfunction

    function automatic logic exp_bit(input logic [7:0] v, input int idx);
        if (idx < 8) return v[idx];
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe_pulse();
        @(negedge clk);
        strobe_i = 1'b1;
        @(negedge clk);
        strobe_i = 1'b0;
    endtask

    task automatic push_seq(input int port, input logic [7:0] v,
                            input int first, input int n);
        logic [7:0] l;
        l = model_load(v);
        for (int i = first; i < first + n; i++) begin
            if (port == 0) exp0_q.push_back(exp_bit(l, i));
            else           exp1_q.push_back(exp_bit(l, i));
        end
    endtask

    // Scoreboard: issue one read cycle on the ports in mask, compare data_o
    // during the pulse against the oldest expected bit of each port.
    task automatic sb_read(input logic [1:0] mask);
        logic [0:0] e;
        @(negedge clk);
        rd_pulse_i = mask;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (mask[p]) begin
                tests_run++;
                if ((p == 0 && exp0_q.size() == 0) ||
                    (p == 1 && exp1_q.size() == 0)) begin
                    tests_failed++;
                    $display("FAIL %s read port%0d: got %b, no expected value queued",
                             cur_test, p, data_o[p]);
                end else begin
                    e = (p == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
                    if (data_o[p] !== e[0]) begin
                        tests_failed++;
                        $display("FAIL %s read port%0d: got %b, expected %b",
                                 cur_test, p, data_o[p], e[0]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        rd_pulse_i = 2'b00;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        #1;
        tests_run++;
        if (data_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset data_o: got %b, expected 00", data_o);
        end
        tests_run++;
        if (btn0_state !== 8'h00 || btn1_state !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset btn_state: got %h/%h, expected 00/00",
                     btn0_state, btn1_state);
        end
        strobe_pulse();
        push_seq(0, 8'h00, 0, 9);
        for (int i = 0; i < 9; i++) sb_read(2'b01);
    endtask

    task automatic test_serial_read();
        cur_test = "serial_read";
        btn0_raw = 8'b1000_1001;
        wait_cycles(20);
        tests_run++;
        if (btn0_state !== 8'h89) begin
            tests_failed++;
            $display("FAIL serial_read btn0_state: got %h, expected 89", btn0_state);
        end
        strobe_pulse();
        push_seq(0, 8'h89, 0, 10);
        for (int i = 0; i < 10; i++) sb_read(2'b01);
    endtask

    task automatic test_glitch();
        cur_test = "glitch";
        btn1_raw = 8'h02;
        wait_cycles(6);
        btn1_raw = 8'h00;
        wait_cycles(20);
        tests_run++;
        if (btn1_state !== 8'h00) begin
            tests_failed++;
            $display("FAIL glitch btn1_state: got %h, expected 00", btn1_state);
        end
        strobe_pulse();
        push_seq(1, 8'h00, 0, 2);
        sb_read(2'b10);
        sb_read(2'b10);
    endtask

    task automatic test_strobe_high();
        cur_test = "strobe_high";
        btn0_raw = 8'h01;
        wait_cycles(20);
        tests_run++;
        if (btn0_state !== 8'h01) begin
            tests_failed++;
            $display("FAIL strobe_high btn0_state: got %h, expected 01", btn0_state);
        end
        @(negedge clk);
        strobe_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp0_q.push_back(1'b1);
            sb_read(2'b01);
        end
        strobe_i = 1'b0;
        push_seq(0, 8'h01, 0, 2);
        sb_read(2'b01);
        sb_read(2'b01);
    endtask

    task automatic test_back_to_back();
        cur_test = "back_to_back";
        btn0_raw = 8'hFF;
        btn1_raw = 8'h00;
        wait_cycles(20);
        tests_run++;
        if (btn0_state !== 8'hFF || btn1_state !== 8'h00) begin
            tests_failed++;
            $display("FAIL back_to_back btn_state: got %h/%h, expected ff/00",
                     btn0_state, btn1_state);
        end
        strobe_pulse();
        push_seq(0, 8'hFF, 0, 1); sb_read(2'b01);
        push_seq(1, 8'h00, 0, 1); sb_read(2'b10);
        push_seq(0, 8'hFF, 1, 1);
        push_seq(1, 8'h00, 1, 1); sb_read(2'b11);
        // Six more port-1 reads finish its eight buttons, the ninth reads 1.
        push_seq(1, 8'h00, 2, 7);
        for (int i = 0; i < 7; i++) sb_read(2'b10);
    endtask

    task automatic test_random_interleave();
        logic [7:0] v0;
        logic [7:0] v1;
        logic [1:0] mask;
        int idx0;
        int idx1;
        cur_test = "random_interleave";
        v0 = 8'hA5;
        v1 = 8'h3C;
        btn0_raw = v0;
        btn1_raw = v1;
        wait_cycles(20);
        tests_run++;
        if (btn0_state !== v0 || btn1_state !== v1) begin
            tests_failed++;
            $display("FAIL random_interleave btn_state: got %h/%h, expected %h/%h",
                     btn0_state, btn1_state, v0, v1);
        end
        strobe_pulse();
        idx0 = 0;
        idx1 = 0;
        for (int i = 0; i < 20; i++) begin
            mask = 2'($urandom_range(1, 3));
            if (mask[0]) begin push_seq(0, v0, idx0, 1); idx0++; end
            if (mask[1]) begin push_seq(1, v1, idx1, 1); idx1++; end
            sb_read(mask);
        end
    endtask

    task automatic test_socd();
        cur_test = "socd";
        btn0_raw = 8'h30;
        btn1_raw = 8'hC0;
        wait_cycles(20);
        tests_run++;
        if (btn0_state !== 8'h30 || btn1_state !== 8'hC0) begin
            tests_failed++;
            $display("FAIL socd btn_state: got %h/%h, expected 30/c0",
                     btn0_state, btn1_state);
        end
        strobe_pulse();
        push_seq(0, 8'h30, 0, 8);
        push_seq(1, 8'hC0, 0, 8);
        for (int i = 0; i < 8; i++) sb_read(2'b11);
    endtask

    task automatic test_reset_mid();
        cur_test = "reset_mid";
        btn0_raw = 8'h89;
        btn1_raw = 8'hFF;
        wait_cycles(20);
        strobe_pulse();
        push_seq(0, 8'h89, 0, 3);
        for (int i = 0; i < 3; i++) sb_read(2'b01);
        // Start bit is now on port 0, all ones on port 1.
        tests_run++;
        if (data_o !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid pre-reset data_o: got %b, expected 11", data_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (data_o !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mid data_o: got %b, expected 00", data_o);
        end
        tests_run++;
        if (btn0_state !== 8'h00 || btn1_state !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mid btn_state: got %h/%h, expected 00/00",
                     btn0_state, btn1_state);
        end
        @(negedge clk);
        rst = 1'b0;
        exp0_q.push_back(1'b0);
        sb_read(2'b01);
    endtask

    // ------------------------------------------------------------------
    // Sequencer and final report
    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        btn0_raw   = 8'h00;
        btn1_raw   = 8'h00;
        strobe_i   = 1'b0;
        rd_pulse_i = 2'b00;

        test_reset();
        test_serial_read();
        test_glitch();
        test_strobe_high();
        test_back_to_back();
        test_random_interleave();
        test_socd();
        test_reset_mid();

        tests_run++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard drain: %0d/%0d entries left, expected 0/0",
                     exp0_q.size(), exp1_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
